// File: rtl/snn_pkg.sv
// Shared definitions for the LIF neuron bank: bank size, FP32 constants and
// the state encoding used by the potential accumulator.
package snn_pkg;

  localparam int NUM_NEURONS_DEFAULT = 30;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/fp32_add.sv
// Combinational IEEE-754 single adder/subtractor (op=1 subtracts b), round to
// nearest even, gradual underflow; exception flags Inf/NaN inputs and overflow.
module fp32_add
  import snn_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        exception,
  output logic [31:0] result
);

  logic        sa, sb, sx, sy, swap, g, rs, up;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  ea, eb, ex, ey, d;
  logic [23:0] ma, mb, mx, my, mant;
  logic [26:0] yfull, ysh, n27;
  logic [27:0] sum;
  logic [24:0] mant_r;
  int          e, sh;

  always_comb begin
    sa    = a[31];
    sb    = b[31] ^ op;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    // Subnormals carry no hidden bit but share the exponent of the smallest normal.
    ea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma    = {(a[30:23] != 8'd0), a[22:0]};
    mb    = {(b[30:23] != 8'd0), b[22:0]};

    swap  = {eb, mb} > {ea, ma};
    sx    = swap ? sb : sa;
    sy    = swap ? sa : sb;
    ex    = swap ? eb : ea;
    ey    = swap ? ea : eb;
    mx    = swap ? mb : ma;
    my    = swap ? ma : mb;
    d     = ex - ey;

    // Guard, round and a sticky bit that absorbs everything shifted out.
    yfull = {my, 3'b000};
    if (d >= 8'd27) ysh = {26'd0, (my != 24'd0)};
    else ysh = (yfull >> d) | {26'd0, ((yfull & ((27'd1 << d) - 27'd1)) != 27'd0)};

    sum = (sx == sy) ? ({1'b0, mx, 3'b000} + {1'b0, ysh})
                     : ({1'b0, mx, 3'b000} - {1'b0, ysh});

    e  = int'(ex);
    sh = 0;
    if (sum[27]) begin
      n27 = {sum[27:2], sum[1] | sum[0]};
      e   = e + 1;
    end else begin
      for (int i = 0; i < 27; i++) if (sum[i]) sh = 26 - i;
      if (sh > e - 1) sh = e - 1;
      n27 = sum[26:0] << sh;
      e   = e - sh;
    end

    mant   = n27[26:3];
    g      = n27[2];
    rs     = n27[1] | n27[0];
    up     = g & (rs | mant[0]);
    mant_r = {1'b0, mant} + {24'd0, up};
    if (mant_r[24]) begin
      mant = mant_r[24:1];
      e    = e + 1;
    end else begin
      mant = mant_r[23:0];
    end

    exception = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      result    = FP32_QNAN;
      exception = 1'b1;
    end else if (a_inf || b_inf) begin
      result    = {(a_inf ? sa : sb), 8'hFF, 23'd0};
      exception = 1'b1;
    end else if (sum == 28'd0) begin
      result = {sx & sy, 31'd0};
    end else if (e >= 255) begin
      result    = {sx, 8'hFF, 23'd0};
      exception = 1'b1;
    end else begin
      result = {sx, (mant[23] ? 8'(e) : 8'd0), mant[22:0]};
    end
  end

endmodule

// File: rtl/potential_adder.sv
// Per-timestep synaptic accumulator: adds FP32 weights into each neuron's
// stored potential and streams all potentials in address order at timestep end.
module potential_adder
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEFAULT,
  parameter int ADDR_W      = 5
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              init_valid,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_potential,
  input  logic              syn_valid,
  output logic              syn_ready,
  input  logic [ADDR_W-1:0] syn_addr,
  input  logic [31:0]       syn_weight,
  input  logic              timestep_end,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              busy,
  output logic              overrun,
  output logic              fp_exception,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W:0]   NUM_LIMIT = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] flush_cnt;
  logic [31:0]       pot_mem [NUM_NEURONS];
  logic              syn_fire, syn_in_range, init_in_range;
  logic [ADDR_W-1:0] syn_idx;
  logic [31:0]       add_result;
  logic              add_exception;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds its payload stable while valid is high and
  // ready is low. syn_* and out_* both follow this rule.
  assign syn_ready     = (state != ST_FLUSH) && !init_valid;
  assign syn_fire      = syn_valid && syn_ready;
  assign syn_in_range  = {1'b0, syn_addr} < NUM_LIMIT;
  assign init_in_range = {1'b0, init_addr} < NUM_LIMIT;
  assign syn_idx       = syn_in_range ? syn_addr : '0;

  assign busy          = (state == ST_FLUSH);
  assign out_valid     = busy;
  assign out_addr      = flush_cnt;
  assign out_potential = busy ? pot_mem[flush_cnt] : FP32_ZERO;
  assign dbg_state     = state;

  fp32_add u_fp32_add (
    .a         (pot_mem[syn_idx]),
    .b         (syn_weight),
    .op        (1'b0),
    .exception (add_exception),
    .result    (add_result)
  );

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      flush_cnt    <= '0;
      overrun      <= 1'b0;
      fp_exception <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) pot_mem[i] <= FP32_ZERO;
    end else begin
      // Init wins; syn_ready already blocks a weight in the same cycle.
      if (init_valid && init_in_range) begin
        pot_mem[init_addr] <= init_potential;
      end else if (syn_fire && syn_in_range) begin
        pot_mem[syn_addr] <= add_result;
        if (add_exception) fp_exception <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (timestep_end)  state <= ST_FLUSH;
          else if (syn_fire) state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (timestep_end) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (timestep_end) overrun <= 1'b1;
          if (out_ready) begin
            if (flush_cnt == LAST_ADDR) begin
              state     <= ST_IDLE;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/potential_adder.md
# potential_adder

Per-timestep synaptic accumulator for the 30-neuron LIF bank. It sums incoming FP32 synaptic weights into each neuron's stored membrane potential. At timestep end it streams every neuron's new potential, in address order, to the potential-decay stage as that stage's `new_potential` input. Decayed potentials are written back through the init port before the next timestep.

## Interface
Parameters:
- `NUM_NEURONS`, 30, neurons in the bank
- `ADDR_W`, 5, neuron address width; must satisfy 2^ADDR_W ≥ NUM_NEURONS

Ports:
- `CLK`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `init_valid`  in  1  write `init_potential` into neuron `init_addr` (decay write-back or initialisation)
- `init_addr`  in  ADDR_W  target neuron for init
- `init_potential`  in  32  IEEE-754 single value to store
- `syn_valid`  in  1  synaptic weight present
- `syn_ready`  out  1  accumulator accepts weight this cycle
- `syn_addr`  in  ADDR_W  target neuron
- `syn_weight`  in  32  IEEE-754 single weight, signed
- `timestep_end`  in  1  single-cycle pulse that closes the timestep
- `out_valid`  out  1  `out_potential` valid for `out_addr`
- `out_ready`  in  1  decay stage consumes the current output
- `out_addr`  out  ADDR_W  neuron index being streamed
- `out_potential`  out  32  accumulated potential of `out_addr`
- `busy`  out  1  high while in FLUSH
- `overrun`  out  1  sticky: `timestep_end` arrived during FLUSH
- `fp_exception`  out  1  sticky: adder flagged an exception

## Operation
- Storage is `pot_mem[NUM_NEURONS]` × 32 bits.
- FSM states are IDLE, ACCUM and FLUSH.
  - IDLE → ACCUM on the first accepted weight.
  - IDLE or ACCUM → FLUSH when `timestep_end` = 1.
  - FLUSH → IDLE after the handshake on address NUM_NEURONS−1.
- `syn_ready` = (state ≠ FLUSH) && !`init_valid`. Init always has priority, so init and accumulate never collide.
- Accept (`syn_valid` && `syn_ready`): `pot_mem[syn_addr]` ← `pot_mem[syn_addr]` + `syn_weight` through the combinational FP adder, written in one cycle. Throughput is one weight per cycle, including back-to-back writes to the same address.
- Init: `pot_mem[init_addr]` ← `init_potential`. Init is accepted in every state, including FLUSH.
- Out-of-range addresses (≥ NUM_NEURONS) are dropped, but the handshake still completes.
- FLUSH:
  - `flush_cnt` starts at 0.
  - `out_valid` = 1, `out_addr` = `flush_cnt`, `out_potential` = `pot_mem[flush_cnt]`, all held stable until `out_ready`.
  - Each handshake increments `flush_cnt`.
  - Memory is not cleared by the flush; the decay stage overwrites it via init.
- `timestep_end` in FLUSH is ignored and sets `overrun`. `timestep_end` coincident with an accepted weight: the weight is accumulated first, and the flush sees it.
- Adder exception (Inf/NaN): the result is written unchanged and `fp_exception` is set.

## Timing
- Reset (`reset_n` = 0 at an edge):
  - state=IDLE, `flush_cnt`=0, all `pot_mem`=32'h00000000.
  - `syn_ready`=1, `out_valid`=0, `out_addr`=0, `out_potential`=0, `busy`=0, `overrun`=0, `fp_exception`=0.
  - Reset mid-FLUSH aborts the stream immediately.
- A weight accepted at edge N is readable (flush or next add) from cycle N+1.
- `timestep_end` sampled at edge N gives `out_valid`=1 and `busy`=1 from cycle N+1.
- Flush of NUM_NEURONS entries with `out_ready` tied high takes NUM_NEURONS cycles. IDLE is re-entered at the edge completing address NUM_NEURONS−1, and `syn_ready` rises the cycle after.
- `out_ready` low stalls indefinitely; all outputs stay stable.
- Init during FLUSH to the address currently presented updates `out_potential` from the next cycle. The decay stage must not do this; it is legal but undefined in intent.

## Structure
- Shared package `snn_pkg`:
  - `FP32_ZERO`
  - FSM state encoding (`ST_IDLE`, `ST_ACCUM`, `ST_FLUSH`)
  - `NUM_NEURONS` default
- One sub-module: `fp32_add`, a combinational IEEE-754 single adder/subtractor with operands a, b, op and outputs exception, result, shared with the decay stage. The adder is used with op=0.
- Everything else (FSM, counter, memory, sticky flags) is flat in `potential_adder`.

## Test plan
- Reset, then `timestep_end` with `out_ready`=1 → 30 outputs, addr 0..29, all 32'h00000000, `busy` high exactly 30 cycles.
- Weights 0x3F800000 (1.0) then 0x3F000000 (0.5) to addr 3 on consecutive cycles, then flush → addr 3 = 0x3FC00000 (1.5), all others 0.
- Init addr 7 = 0x40000000 (2.0), add 0x3F000000 (0.5), add 0xBF800000 (−1.0) → flush addr 7 = 0x3FC00000; `init_valid` with `syn_valid` → `syn_ready`=0 and the weight is not taken.
- Flush with `out_ready` toggling 1,0,0,1… → no address skipped or repeated, outputs stable while stalled; `timestep_end` mid-flush → `overrun`=1, stream unaffected.
- Weight 0x7F7FFFFF + 0x7F7FFFFF → `fp_exception`=1, sticky until reset; `reset_n` low mid-flush → next cycle `out_valid`=0, memory zeroed.
